// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and the default NOP byte.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10
  } state_e;

  localparam logic [7:0] NopDefault = 8'h00;

  // Address width for a byte memory of the given depth; a 1-entry memory still needs one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Byte-wide instruction storage: one synchronous write port, one asynchronous read port,
// asynchronous clear of every location to the NOP byte.
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter logic [7:0]  NOP   = 8'h00
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program into local memory, then serves it to a single-cycle core
// with zero-latency reads while in RUN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter logic [7:0]  NOP   = NopDefault
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       prog_valid,
  input  logic [7:0] prog_data,
  input  logic       prog_last,
  output logic       prog_ready,
  input  logic [7:0] read_address,
  output logic [7:0] instruction,
  output logic       run,
  output logic [8:0] prog_len,
  output logic       overrun
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] wptr_q;
  logic [8:0]    prog_len_q;
  logic          overrun_q;
  logic          run_q;
  logic          ready_q;

  logic          xfer;
  logic          at_end;
  logic [7:0]    rdata;

  // ready_q is only ever high in StLoad, so a transfer implies the LOAD state.
  assign xfer   = prog_valid & ready_q;
  assign at_end = (wptr_q == LastAddr);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      prog_len_q <= '0;
      overrun_q  <= 1'b0;
      run_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            wptr_q     <= '0;
            prog_len_q <= '0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (xfer) begin
            prog_len_q <= prog_len_q + 9'd1;
            if (prog_last || at_end) begin
              // Filling the last location without prog_last means bytes were lost.
              overrun_q <= ~prog_last;
              ready_q   <= 1'b0;
              run_q     <= 1'b1;
              state_q   <= StRun;
            end else begin
              wptr_q <= wptr_q + AW'(1);
            end
          end
        end
        StRun: begin
          if (stop) begin
            run_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b0;
          run_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NOP   (NOP)
  ) u_imem (
    .CLK   (CLK),
    .reset (reset),
    .we    (xfer),
    .waddr (wptr_q),
    .wdata (prog_data),
    .raddr (read_address[AW-1:0]),
    .rdata (rdata)
  );

  // The length bound uses the full 8-bit address even when the memory decodes fewer bits.
  always_comb begin
    instruction = NOP;
    if (run_q && ({1'b0, read_address} < prog_len_q)) begin
      instruction = rdata;
    end
  end

  assign prog_ready = ready_q;
  assign run        = run_q;
  assign prog_len   = prog_len_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-depth instance plus a DEPTH=16 instance
// for the overrun scenario.
module tb_instruction_loader;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_last = 1'b0;
  logic [7:0] read_address = 8'h00;
  logic       prog_ready;
  logic [7:0] instruction;
  logic       run;
  logic [8:0] prog_len;
  logic       overrun;

  logic       s16_start = 1'b0;
  logic       s16_stop = 1'b0;
  logic       s16_valid = 1'b0;
  logic [7:0] s16_data = 8'h00;
  logic       s16_last = 1'b0;
  logic       s16_ready;
  logic [7:0] s16_instr;
  logic       s16_run;
  logic [8:0] s16_len;
  logic       s16_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  instruction_loader dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .prog_valid   (prog_valid),
    .prog_data    (prog_data),
    .prog_last    (prog_last),
    .prog_ready   (prog_ready),
    .read_address (read_address),
    .instruction  (instruction),
    .run          (run),
    .prog_len     (prog_len),
    .overrun      (overrun)
  );

  instruction_loader #(
    .DEPTH (16)
  ) dut16 (
    .CLK          (CLK),
    .reset        (reset),
    .start        (s16_start),
    .stop         (s16_stop),
    .prog_valid   (s16_valid),
    .prog_data    (s16_data),
    .prog_last    (s16_last),
    .prog_ready   (s16_ready),
    .read_address (read_address),
    .instruction  (s16_instr),
    .run          (s16_run),
    .prog_len     (s16_len),
    .overrun      (s16_overrun)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one byte after 'gap' idle cycles; the byte transfers on the following edge.
  task automatic load_byte(input logic [7:0] data, input logic last, input int gap);
    prog_valid = 1'b0;
    repeat (gap) tick();
    prog_valid = 1'b1;
    prog_data  = data;
    prog_last  = last;
    vectors++;
    if (prog_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready data=%h: got %b want 1", data, prog_ready);
    end
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({run, prog_ready, overrun, prog_len} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got run=%b rdy=%b ovr=%b len=%0d want all 0",
               run, prog_ready, overrun, prog_len);
    end
    read_address = 8'h00;
    #1;
    vectors++;
    if (instruction !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_instr: got %h want 00", instruction);
    end
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({run, prog_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got run=%b rdy=%b want 0 0", run, prog_ready);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h00;
    pulse_start();
    vectors++;
    if ({prog_ready, run} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_to_load: got rdy=%b run=%b want 1 0", prog_ready, run);
    end
    load_byte(8'h11, 1'b0, 0);
    load_byte(8'h22, 1'b0, 0);
    load_byte(8'h33, 1'b1, 0);
    vectors++;
    if ({run, prog_ready, overrun, prog_len} !== {3'b100, 9'd3}) begin
      miscompares++;
      $display("FAIL basic_done: got run=%b rdy=%b ovr=%b len=%0d want 1 0 0 3",
               run, prog_ready, overrun, prog_len);
    end
    for (int i = 0; i < 4; i++) begin
      read_address = 8'(i);
      #1;
      vectors++;
      if (instruction !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_read[%0d]: got %h want %h", i, instruction, exp[i]);
      end
    end
    read_address = 8'hFF;
    #1;
    vectors++;
    if (instruction !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_read_ff: got %h want 00", instruction);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    pulse_stop();
    read_address = 8'h00;
    #1;
    vectors++;
    if ({run, instruction} !== 9'h000) begin
      miscompares++;
      $display("FAIL stop_to_idle: got run=%b instr=%h want 0 00", run, instruction);
    end
    tick();
    pulse_start();
    load_byte(8'h11, 1'b0, 1);
    repeat (5) tick();
    vectors++;
    if ({prog_len, prog_ready} !== {9'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL gap_hold: got len=%0d rdy=%b want 1 1", prog_len, prog_ready);
    end
    load_byte(8'h22, 1'b0, 3);
    load_byte(8'h33, 1'b1, 2);
    vectors++;
    if ({run, prog_len} !== {1'b1, 9'd3}) begin
      miscompares++;
      $display("FAIL gap_done: got run=%b len=%0d want 1 3", run, prog_len);
    end
    for (int i = 0; i < 3; i++) begin
      read_address = 8'(i);
      #1;
      vectors++;
      if (instruction !== exp[i]) begin
        miscompares++;
        $display("FAIL gap_read[%0d]: got %h want %h", i, instruction, exp[i]);
      end
    end
    // start must be ignored while running
    pulse_start();
    vectors++;
    if ({run, prog_ready, prog_len} !== {2'b10, 9'd3}) begin
      miscompares++;
      $display("FAIL start_in_run: got run=%b rdy=%b len=%0d want 1 0 3",
               run, prog_ready, prog_len);
    end
  endtask

  task automatic test_overrun();
    int accepted = 0;
    s16_start = 1'b1;
    tick();
    s16_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s16_valid = 1'b1;
      s16_data  = 8'h40 + 8'(i);
      #1;
      if (s16_ready === 1'b1) accepted++;
      tick();
    end
    s16_valid = 1'b0;
    vectors++;
    if (accepted !== 16) begin
      miscompares++;
      $display("FAIL ovr_accepted: got %0d want 16", accepted);
    end
    vectors++;
    if ({s16_run, s16_overrun, s16_ready, s16_len} !== {3'b110, 9'd16}) begin
      miscompares++;
      $display("FAIL ovr_flags: got run=%b ovr=%b rdy=%b len=%0d want 1 1 0 16",
               s16_run, s16_overrun, s16_ready, s16_len);
    end
    read_address = 8'h00;
    #1;
    vectors++;
    if (s16_instr !== 8'h40) begin
      miscompares++;
      $display("FAIL ovr_read0: got %h want 40", s16_instr);
    end
    read_address = 8'h0F;
    #1;
    vectors++;
    if (s16_instr !== 8'h4F) begin
      miscompares++;
      $display("FAIL ovr_read15: got %h want 4f", s16_instr);
    end
    read_address = 8'h10;
    #1;
    vectors++;
    if (s16_instr !== 8'h00) begin
      miscompares++;
      $display("FAIL ovr_read16: got %h want 00", s16_instr);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_stop();
    pulse_start();
    load_byte(8'hC1, 1'b0, 0);
    load_byte(8'hC2, 1'b0, 0);
    reset = 1'b0;
    #2;
    vectors++;
    if ({run, prog_ready, prog_len} !== 11'h000) begin
      miscompares++;
      $display("FAIL mid_reset: got run=%b rdy=%b len=%0d want 0 0 0",
               run, prog_ready, prog_len);
    end
    @(negedge CLK);
    reset = 1'b1;
    tick();
    read_address = 8'h00;
    #1;
    vectors++;
    if (instruction !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_read: got %h want 00", instruction);
    end
    pulse_start();
    load_byte(8'hAA, 1'b0, 0);
    load_byte(8'hBB, 1'b1, 0);
    read_address = 8'h01;
    #1;
    vectors++;
    if ({run, prog_len, instruction} !== {1'b1, 9'd2, 8'hBB}) begin
      miscompares++;
      $display("FAIL reload: got run=%b len=%0d instr=%h want 1 2 bb",
               run, prog_len, instruction);
    end
  endtask

  task automatic test_stop_restart();
    pulse_stop();
    pulse_start();
    load_byte(8'hA5, 1'b1, 0);
    read_address = 8'h00;
    #1;
    vectors++;
    if ({prog_len, instruction} !== {9'd1, 8'hA5}) begin
      miscompares++;
      $display("FAIL restart_read0: got len=%0d instr=%h want 1 a5", prog_len, instruction);
    end
    // location 1 still holds BB from the previous program but lies beyond prog_len
    read_address = 8'h01;
    #1;
    vectors++;
    if (instruction !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_read1: got %h want 00", instruction);
    end
  endtask

  task automatic test_start_stop_both();
    pulse_stop();
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({prog_ready, run} !== 2'b10) begin
      miscompares++;
      $display("FAIL both_in_load: got rdy=%b run=%b want 1 0", prog_ready, run);
    end
    load_byte(8'h77, 1'b1, 0);
    vectors++;
    if ({run, prog_len} !== {1'b1, 9'd1}) begin
      miscompares++;
      $display("FAIL both_done: got run=%b len=%0d want 1 1", run, prog_len);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_gaps();
    test_overrun();
    test_reset_mid_load();
    test_stop_restart();
    test_start_stop_both();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction memory depth in bytes, a power of two and at most 256.
REQ-002 SHALL have parameter NOP, default 8'h00: instruction byte driven whenever no valid instruction is presented.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: level; requests a new program load when sampled high in IDLE.
REQ-006 SHALL have port stop, input, 1: level; returns RUN to IDLE.
REQ-007 SHALL have port prog_valid, input, 1: a program byte is offered.
REQ-008 SHALL have port prog_data, input, 8: the offered program byte.
REQ-009 SHALL have port prog_last, input, 1: the offered byte is the final one.
REQ-010 SHALL have port prog_ready, output, 1: the loader accepts a byte this cycle.
REQ-011 SHALL have port read_address, input, 8: program counter from the processor core.
REQ-012 SHALL have port instruction, output, 8: instruction byte delivered to the processor core.
REQ-013 SHALL have port run, output, 1: processor may advance; high only in RUN.
REQ-014 SHALL have port prog_len, output, 9: number of bytes loaded, 0..DEPTH.
REQ-015 SHALL have port overrun, output, 1: sticky flag; the program exceeded DEPTH.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD and RUN.
REQ-017 SHALL, in IDLE with start=1, clear the write pointer, prog_len and overrun, and enter LOAD on the next edge.
REQ-018 SHALL drive prog_ready=1 only in LOAD; a byte transfers on an edge where prog_valid and prog_ready are both 1.
REQ-019 SHALL, on each transfer, write prog_data to mem[wptr], increment wptr, and increment prog_len.
REQ-020 SHALL enter RUN on the edge of a transfer with prog_last=1, or on the transfer into address DEPTH-1.
REQ-021 SHALL, on the transfer into address DEPTH-1 with prog_last=0, set overrun=1; wptr never wraps.
REQ-022 SHALL leave memory and all counters unchanged while prog_valid=0 in LOAD; there is no timeout.
REQ-023 SHALL ignore start in LOAD and RUN.
REQ-024 SHALL, in RUN, return to IDLE on the next edge when stop=1; in any state other than RUN, stop has no effect.
REQ-025 SHALL drive instruction combinationally as mem[read_address] when state=RUN and read_address < prog_len; otherwise it SHALL drive NOP.
REQ-026 SHALL give read_address to instruction zero-cycle latency, matching a single-cycle core.
REQ-027 SHALL ignore the upper address bits when DEPTH < 256; the prog_len bound still applies to the full 8-bit read_address.
REQ-028 SHALL write no memory location in IDLE or RUN.
REQ-029 SHALL retain memory contents across a RUN-to-IDLE transition.
REQ-030 SHALL drive run registered, equal to (state==RUN).

Reset
REQ-031 SHALL, when reset=0 (asynchronous), set state=IDLE, wptr=0, prog_len=0, overrun=0, run=0 and prog_ready=0, and clear every memory location to NOP.
REQ-032 SHALL, on a reset assertion mid-LOAD, discard the partial program; instruction reads NOP until the next completed load.
REQ-033 SHALL leave the FSM in IDLE after reset deassertion until start is sampled high.

Structure
REQ-034 SHALL place the state encoding (IDLE=2'b00, LOAD=2'b01, RUN=2'b10) and the NOP constant in the shared package.
REQ-035 SHALL implement the storage as one sub-module, imem_array: DEPTH x 8, one synchronous write port, one asynchronous read port, asynchronous clear.
REQ-036 SHALL keep the FSM, pointer and flag logic in instruction_loader, targeting 150-250 RTL lines in total.

Verification
REQ-037 Bench: reset, start, load bytes 8'h11,8'h22,8'h33 (last on 8'h33) -> prog_len=3, run=1; read_address 0,1,2,3 -> 8'h11, 8'h22, 8'h33, 8'h00.
REQ-038 Bench: insert prog_valid=0 gaps of 1-5 cycles between bytes -> memory and prog_len identical to the gap-free load.
REQ-039 Bench: with DEPTH=16, stream 20 bytes, never asserting prog_last -> 16 accepted, RUN entered, overrun=1, prog_ready=0 thereafter.
REQ-040 Bench: assert reset=0 after the 2nd of 4 load bytes -> state IDLE, prog_len=0, all reads 8'h00; a fresh load succeeds.
REQ-041 Bench: in RUN, pulse stop, then start, then load 8'hA5 with prog_last -> prog_len=1, read_address 0 -> 8'hA5, read_address 1 -> 8'h00.
REQ-042 Bench: hold start and stop both high in IDLE -> LOAD entered; stop ignored; run stays 0 until loading completes.
